rx_os_sequencer: RTL and testbench

Multi-lane, multi-symbol-per-clock receive-side ordered-set sequencer for the PHY-to-MAC path. It replays TS1, TS2 and SKP ordered sets into the MAC receive interface according to the local LTSSM state. It fills the per-lane link and lane number fields and marks K-symbols by construction, not by value compare. It sits between the LTSSM model and the MAC receive port, and generalises the single-lane, one-symbol-per-clock rx driver.

---
 rtl/rx_os_pkg.sv | 52 +++++
 rtl/rx_os_symbol_gen.sv | 57 +++++
 rtl/rx_os_sequencer.sv | 151 +++++++++++++++
 tb/tb_rx_os_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_os_pkg.sv
// Shared types, symbol constants and LTSSM-to-ordered-set mapping for the rx ordered-set sequencer.
package rx_os_pkg;

    typedef enum logic [4:0] {
        DETECT_QUIET            = 5'h00,
        DETECT_ACTIVE           = 5'h01,
        POLLING_ACTIVE          = 5'h02,
        POLLING_COMPLIANCE      = 5'h03,
        POLLING_CONFIG          = 5'h04,
        CONFIG_LINKWIDTH_START  = 5'h05,
        CONFIG_LINKWIDTH_ACCEPT = 5'h06,
        CONFIG_LANENUM_WAIT     = 5'h07,
        CONFIG_LANENUM_ACCEPT   = 5'h08,
        CONFIG_COMPLETE         = 5'h09,
        CONFIG_IDLE             = 5'h0A,
        L0                      = 5'h0B,
        RECOVERY_RCVRLOCK       = 5'h0C
    } ltssm_state_t;

    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] SKP       = 8'h1C;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] TS1_ID    = 8'h4A;
    localparam logic [7:0] TS2_ID    = 8'h45;
    localparam logic [7:0] N_FTS_DEF = 8'hFF;
    localparam logic [7:0] RATE_DEF  = 8'h02;

    typedef enum logic [1:0] {OS_IDLE, OS_TS1, OS_TS2, OS_SKP} os_type_t;

    // How the TS link/lane fields are filled for a given LTSSM state.
    typedef enum logic [1:0] {FM_PAD_PAD, FM_LINK_PAD, FM_LINK_LANE} field_mode_t;

    typedef enum logic [1:0] {ST_IDLE, ST_TS, ST_SKP} seq_state_t;

    function automatic field_mode_t ts_field_mode(input ltssm_state_t s);
        case (s)
            CONFIG_LINKWIDTH_START, CONFIG_LINKWIDTH_ACCEPT: return FM_LINK_PAD;
            CONFIG_LANENUM_ACCEPT, CONFIG_COMPLETE:          return FM_LINK_LANE;
            default:                                         return FM_PAD_PAD;
        endcase
    endfunction

    function automatic os_type_t ts_type(input ltssm_state_t s);
        case (s)
            POLLING_ACTIVE, CONFIG_LINKWIDTH_START,
            CONFIG_LINKWIDTH_ACCEPT, CONFIG_LANENUM_ACCEPT: return OS_TS1;
            POLLING_CONFIG, CONFIG_COMPLETE:                return OS_TS2;
            default:                                        return OS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rx_os_symbol_gen.sv
// Combinational lookup of one ordered-set symbol and its K flag from type, index and field mode.
module rx_os_symbol_gen
    import rx_os_pkg::*;
(
    input  os_type_t    os_type,
    input  logic [3:0]  sym_idx,
    input  field_mode_t field_mode,
    input  logic [7:0]  link_num,
    input  logic [7:0]  lane_idx,
    output logic [7:0]  sym,
    output logic        k
);

    always_comb begin
        sym = 8'h00;
        k   = 1'b0;
        case (os_type)
            OS_TS1, OS_TS2: begin
                case (sym_idx)
                    4'd0: begin
                        sym = COM;
                        k   = 1'b1;
                    end
                    4'd1: begin
                        if (field_mode == FM_PAD_PAD) begin
                            sym = PAD;
                            k   = 1'b1;
                        end else begin
                            sym = link_num;
                        end
                    end
                    4'd2: begin
                        if (field_mode == FM_LINK_LANE) begin
                            sym = lane_idx;
                        end else begin
                            sym = PAD;
                            k   = 1'b1;
                        end
                    end
                    4'd3: sym = N_FTS_DEF;
                    4'd4: sym = RATE_DEF;
                    4'd5: sym = 8'h00;
                    default: sym = (os_type == OS_TS1) ? TS1_ID : TS2_ID;
                endcase
            end
            OS_SKP: begin
                sym = (sym_idx == 4'd0) ? COM : SKP;
                k   = 1'b1;
            end
            default: begin
                sym = 8'h00;
                k   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rx_os_sequencer.sv
// Replays TS1/TS2 (and SKP with RX_OS_SKP_INSERT_EN) ordered sets into the MAC rx port.
// Outputs registered, symbol 0 one beat after the type is sampled; no backpressure, free-running.
module rx_os_sequencer
    import rx_os_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int SYM_PER_CLK  = 1,
    parameter int SKP_INTERVAL = 8
) (
    input  logic                               clk,
    input  logic                               p2md_rstn,
    input  logic                               en_n,
    input  ltssm_state_t                       ltssm_state,
    input  logic [7:0]                         link_num,
    output logic [NUM_LANES*SYM_PER_CLK*8-1:0] rxdata,
    output logic [NUM_LANES*SYM_PER_CLK-1:0]   rxdatak,
    output logic [NUM_LANES-1:0]               rxvalid,
    output logic                               os_done,
    output logic [15:0]                        os_count
);

    localparam int         NSYM = NUM_LANES * SYM_PER_CLK;
    localparam logic [4:0] STEP = 5'(SYM_PER_CLK);

    seq_state_t           state, state_d;
    logic [3:0]           ptr, ptr_d;
    os_type_t             cur_type, type_d, sample_type;
    field_mode_t          cur_mode, mode_d;
    logic [7:0]           cur_link, link_d;
    logic [4:0]           ptr_end;
    logic                 os_last;
    logic                 skp_due;
    logic [NSYM*8-1:0]    gen_dat, rxdata_d;
    logic [NSYM-1:0]      gen_k, rxdatak_d;
    logic [NUM_LANES-1:0] rxvalid_d;
    logic                 os_done_d;
    logic [15:0]          os_count_d;

    assign ptr_end     = {1'b0, ptr} + STEP;
    assign os_last     = ((state == ST_TS) && (ptr_end == 5'd16)) ||
                         ((state == ST_SKP) && (ptr_end == 5'd4));
    assign sample_type = ts_type(ltssm_state);

`ifdef RX_OS_SKP_INSERT_EN
    localparam logic [7:0] SKP_LAST = 8'(SKP_INTERVAL - 1);

    logic [7:0] skp_cnt, skp_cnt_d;

    // A due SKP wins over whatever the LTSSM asks for at this boundary.
    assign skp_due = (state == ST_TS) && os_last && (skp_cnt == SKP_LAST);

    always_comb begin
        skp_cnt_d = skp_cnt;
        if ((state == ST_IDLE) || skp_due) begin
            skp_cnt_d = '0;
        end else if (os_last) begin
            skp_cnt_d = ((state == ST_TS) && (sample_type != OS_IDLE)) ? skp_cnt + 8'd1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!p2md_rstn || en_n) begin
            skp_cnt <= '0;
        end else begin
            skp_cnt <= skp_cnt_d;
        end
    end
`else
    assign skp_due = 1'b0;

    if (SKP_INTERVAL < 1) begin : g_skp_interval_ignored
    end
`endif

    // State register, including the registered outputs.
    always_ff @(posedge clk) begin
        if (!p2md_rstn || en_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cur_type <= OS_IDLE;
            cur_mode <= FM_PAD_PAD;
            cur_link <= '0;
            rxdata   <= '0;
            rxdatak  <= '0;
            rxvalid  <= '0;
            os_done  <= 1'b0;
            os_count <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            cur_type <= type_d;
            cur_mode <= mode_d;
            cur_link <= link_d;
            rxdata   <= rxdata_d;
            rxdatak  <= rxdatak_d;
            rxvalid  <= rxvalid_d;
            os_done  <= os_done_d;
            os_count <= os_count_d;
        end
    end

    // Type, field mode and link number are captured together so an OS never mixes states.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        type_d  = cur_type;
        mode_d  = cur_mode;
        link_d  = cur_link;
        if (skp_due) begin
            state_d = ST_SKP;
            ptr_d   = '0;
            type_d  = OS_SKP;
        end else if ((state == ST_IDLE) || os_last) begin
            ptr_d   = '0;
            type_d  = sample_type;
            mode_d  = ts_field_mode(ltssm_state);
            link_d  = link_num;
            state_d = (sample_type == OS_IDLE) ? ST_IDLE : ST_TS;
        end else begin
            ptr_d = ptr + STEP[3:0];
        end
    end

    always_comb begin
        rxdata_d   = '0;
        rxdatak_d  = '0;
        rxvalid_d  = '0;
        os_done_d  = os_last;
        os_count_d = os_count + {15'd0, os_last};
        if (state != ST_IDLE) begin
            rxdata_d  = gen_dat;
            rxdatak_d = gen_k;
            rxvalid_d = '1;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar s = 0; s < SYM_PER_CLK; s++) begin : g_sym
            rx_os_symbol_gen u_gen (
                .os_type    (cur_type),
                .sym_idx    (ptr + 4'(s)),
                .field_mode (cur_mode),
                .link_num   (cur_link),
                .lane_idx   (8'(l)),
                .sym        (gen_dat[(l*SYM_PER_CLK+s)*8 +: 8]),
                .k          (gen_k[l*SYM_PER_CLK+s])
            );
        end
    end

endmodule

// File: tb/tb_rx_os_sequencer.sv
// Bench for rx_os_sequencer: x1 and x4 symbol-per-clock instances against an ordered-set stream model.
module tb_rx_os_sequencer;
    import rx_os_pkg::*;

`ifdef RX_OS_SKP_INSERT_EN
    localparam bit SKP_ON = 1'b1;
`else
    localparam bit SKP_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en_n = 1'b0;
    ltssm_state_t ltssm = DETECT_QUIET;
    logic [7:0]   link = 8'h00;

    logic [31:0]  rxdata0;
    logic [3:0]   rxdatak0, rxvalid0;
    logic         os_done0;
    logic [15:0]  os_count0;
    logic [127:0] rxdata4;
    logic [15:0]  rxdatak4;
    logic [3:0]   rxvalid4;
    logic         os_done4;
    logic [15:0]  os_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_os_sequencer #(.NUM_LANES(4), .SYM_PER_CLK(1), .SKP_INTERVAL(2)) dut_x1 (
        .clk(clk), .p2md_rstn(rstn), .en_n(en_n), .ltssm_state(ltssm), .link_num(link),
        .rxdata(rxdata0), .rxdatak(rxdatak0), .rxvalid(rxvalid0), .os_done(os_done0), .os_count(os_count0)
    );

    rx_os_sequencer #(.NUM_LANES(4), .SYM_PER_CLK(4), .SKP_INTERVAL(3)) dut_x4 (
        .clk(clk), .p2md_rstn(rstn), .en_n(en_n), .ltssm_state(ltssm), .link_num(link),
        .rxdata(rxdata4), .rxdatak(rxdatak4), .rxvalid(rxvalid4), .os_done(os_done4), .os_count(os_count4)
    );

    // ---------------- reference model: an ordered set is a list of symbols played out in order
    logic [127:0] e_dat  [2] = '{default: '0};
    logic [15:0]  e_k    [2] = '{default: '0};
    logic [3:0]   e_vld  [2] = '{default: '0};
    logic         e_done [2] = '{default: 1'b0};
    logic [15:0]  e_cnt  [2] = '{default: '0};
    int           m_kind [2] = '{0, 0};     // 0 none, 1 TS1, 2 TS2, 3 SKP
    int           m_pos  [2] = '{0, 0};
    int           m_run  [2] = '{0, 0};     // consecutive TS sets since last SKP/idle
    ltssm_state_t m_st   [2] = '{DETECT_QUIET, DETECT_QUIET};
    logic [7:0]   m_link [2] = '{8'h00, 8'h00};
    int           spc_of [2] = '{1, 4};
    int           ivl_of [2] = '{2, 3};

    function automatic int ref_kind(input ltssm_state_t st);
        if (st == POLLING_ACTIVE || st == CONFIG_LINKWIDTH_START ||
            st == CONFIG_LINKWIDTH_ACCEPT || st == CONFIG_LANENUM_ACCEPT) return 1;
        if (st == POLLING_CONFIG || st == CONFIG_COMPLETE) return 2;
        return 0;
    endfunction

    function automatic logic [8:0] ref_sym(input int kind, input ltssm_state_t st,
                                           input logic [7:0] lnk, input int lane, input int idx);
        logic polling, lane_num;
        polling  = (st == POLLING_ACTIVE || st == POLLING_CONFIG);
        lane_num = (st == CONFIG_LANENUM_ACCEPT || st == CONFIG_COMPLETE);
        if (kind == 3) return (idx == 0) ? 9'h1BC : 9'h11C;
        case (idx)
            0:       return 9'h1BC;
            1:       return polling ? 9'h1F7 : {1'b0, lnk};
            2:       return lane_num ? {1'b0, 8'(lane)} : 9'h1F7;
            3:       return 9'h0FF;
            4:       return 9'h002;
            5:       return 9'h000;
            default: return (kind == 1) ? 9'h04A : 9'h045;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn || en_n) begin
                e_dat[d] = '0; e_k[d] = '0; e_vld[d] = '0; e_done[d] = 1'b0; e_cnt[d] = '0;
                m_kind[d] = 0; m_pos[d] = 0; m_run[d] = 0;
            end else begin
                e_dat[d] = '0; e_k[d] = '0; e_vld[d] = '0; e_done[d] = 1'b0;
                if (m_kind[d] != 0) begin
                    for (int ln = 0; ln < 4; ln++) begin
                        for (int s = 0; s < spc_of[d]; s++) begin
                            logic [8:0] sy;
                            sy = ref_sym(m_kind[d], m_st[d], m_link[d], ln, m_pos[d] + s);
                            e_dat[d][(ln*spc_of[d]+s)*8 +: 8] = sy[7:0];
                            e_k[d][ln*spc_of[d]+s] = sy[8];
                        end
                    end
                    e_vld[d] = 4'hF;
                    m_pos[d] = m_pos[d] + spc_of[d];
                    if (m_pos[d] == ((m_kind[d] == 3) ? 4 : 16)) begin
                        e_done[d] = 1'b1;
                        e_cnt[d]  = e_cnt[d] + 16'd1;
                        if (m_kind[d] != 3) m_run[d] = m_run[d] + 1;
                        m_kind[d] = 0;
                    end
                end
                if (m_kind[d] == 0) begin
                    m_pos[d] = 0;
                    if (SKP_ON && m_run[d] == ivl_of[d]) begin
                        m_kind[d] = 3;
                        m_run[d]  = 0;
                    end else begin
                        m_kind[d] = ref_kind(ltssm);
                        m_st[d]   = ltssm;
                        m_link[d] = link;
                        if (m_kind[d] == 0) m_run[d] = 0;
                    end
                end
            end
        end
    end

    // ---------------- checking helpers
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        chk("sb_x1", 256'({rxdata0, rxdatak0, rxvalid0, os_done0, os_count0}),
                     256'({e_dat[0][31:0], e_k[0][3:0], e_vld[0], e_done[0], e_cnt[0]}));
        chk("sb_x4", 256'({rxdata4, rxdatak4, rxvalid4, os_done4, os_count4}),
                     256'({e_dat[1], e_k[1], e_vld[1], e_done[1], e_cnt[1]}));
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        en_n  = 1'b0;
        ltssm = DETECT_QUIET;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    typedef struct {
        ltssm_state_t st;
        logic [7:0]   b;
        logic         k;
        logic         vld;
        logic         done;
        logic [15:0]  cnt;
    } vec_t;

    vec_t         tbl [18];
    logic [7:0]   ts1_pad [16];
    logic [7:0]   skp_b [6];
    logic         skp_k [6];
    logic [15:0]  skp_c [6];
    ltssm_state_t pick [8];

    initial begin
        ts1_pad = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, 8'h4A, 8'h4A,
                    8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
        tbl[0] = '{POLLING_ACTIVE, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{(i == 16) ? DETECT_QUIET : POLLING_ACTIVE, ts1_pad[i-1], (i <= 3),
                       1'b1, (i == 16), (i == 16) ? 16'd1 : 16'd0};
        tbl[17] = '{DETECT_QUIET, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
`ifdef RX_OS_SKP_INSERT_EN
        skp_b = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'hBC, 8'hF7};
        skp_k = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        skp_c = '{16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3};
`else
        skp_b = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00};
        skp_k = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        skp_c = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
`endif
        pick = '{DETECT_QUIET, POLLING_ACTIVE, POLLING_CONFIG, CONFIG_LINKWIDTH_START,
                 CONFIG_LINKWIDTH_ACCEPT, CONFIG_LANENUM_ACCEPT, CONFIG_COMPLETE, L0};

        // reset state
        do_reset();
        chk("reset_x1", 256'({rxdata0, rxdatak0, rxvalid0, os_done0, os_count0}), 256'(0));
        chk("reset_x4", 256'({rxdata4, rxdatak4, rxvalid4, os_done4, os_count4}), 256'(0));

        // TS1 from idle on the x1 instance, lane 0, then drop back to idle
        for (int i = 0; i < 18; i++) begin
            ltssm = tbl[i].st;
            cycle();
            chk($sformatf("tbl%0d", i),
                256'({rxdata0[7:0], rxdatak0[0], rxvalid0, os_done0, os_count0}),
                256'({tbl[i].b, tbl[i].k, {4{tbl[i].vld}}, tbl[i].done, tbl[i].cnt}));
        end

        // four symbols per clock, lane numbers filled in
        do_reset();
        ltssm = CONFIG_LANENUM_ACCEPT;
        link  = 8'h05;
        cycle();
        cycle();
        chk("x4_beat0_lane3", 256'({rxdata4[127:96], rxdatak4[15:12]}), 256'({32'hFF0305BC, 4'b0001}));
        cycle();
        chk("x4_beat1_lane0", 256'({rxdata4[31:0], rxdatak4[3:0]}), 256'({32'h4A4A0002, 4'b0000}));
        cycle();
        chk("x4_beat2_nodone", 256'(os_done4), 256'(0));
        cycle();
        chk("x4_beat3_done", 256'({os_done4, os_count4}), 256'({1'b1, 16'd1}));

        // state change mid-OS does not truncate it
        do_reset();
        ltssm = POLLING_ACTIVE;
        cycle();
        for (int b = 0; b < 16; b++) begin
            cycle();
            if (b == 7) ltssm = POLLING_CONFIG;
        end
        chk("switch_last_ts1", 256'({rxdata0[7:0], os_done0}), 256'({8'h4A, 1'b1}));
        for (int b = 0; b < 7; b++) cycle();
        chk("switch_ts2_id", 256'({rxdata0[7:0], rxdatak0[0]}), 256'({8'h45, 1'b0}));

        // SKP after two TS1 (or plain TS1 when SKP insertion is not built)
        do_reset();
        ltssm = POLLING_ACTIVE;
        cycle();
        for (int b = 0; b < 32; b++) cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("skp%0d", i), 256'({rxdata0[7:0], rxdatak0[0], os_count0}),
                256'({skp_b[i], skp_k[i], skp_c[i]}));
        end

        // reset in the middle of an OS
        do_reset();
        ltssm = POLLING_ACTIVE;
        cycle();
        for (int b = 0; b < 9; b++) cycle();
        rstn = 1'b0;
        cycle();
        chk("rst_mid", 256'({rxdata0, rxdatak0, rxvalid0, os_done0, os_count0}), 256'(0));
        rstn = 1'b1;
        cycle();
        cycle();
        chk("rst_sym0", 256'({rxdata0[7:0], rxdatak0[0], rxvalid0}), 256'({8'hBC, 1'b1, 4'hF}));

        // en_n held high during CONFIG_COMPLETE
        do_reset();
        ltssm = CONFIG_COMPLETE;
        link  = 8'h33;
        cycle();
        for (int b = 0; b < 5; b++) cycle();
        en_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            cycle();
            chk($sformatf("en_n_hi%0d", b), 256'({rxvalid0, rxvalid4, os_count0}), 256'(0));
        end
        en_n = 1'b0;
        cycle();
        chk("en_n_sample", 256'(rxvalid0), 256'(0));
        cycle();
        chk("en_n_sym0", 256'({rxdata0[7:0], rxvalid0}), 256'({8'hBC, 4'hF}));
        cycle();
        cycle();
        chk("en_n_lanefield", 256'({rxdata0, rxdatak0}), 256'({32'h03020100, 4'h0}));

        // randomized LTSSM walk with occasional disable/reset
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(15) == 0) ltssm = pick[$urandom_range(7)];
            if ($urandom_range(31) == 0) link = 8'($urandom_range(255));
            en_n = ($urandom_range(99) == 0);
            rstn = ($urandom_range(199) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
